hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 82 ++++++++
 tb/tb_hazard_scoreboard.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus between the pipeline control and the scoreboard.
// master drives decode/control, slave returns pending tags and stall.
interface hazard_scoreboard_if;
    logic        advance;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_wsel;
    logic        id_regwen;
    logic        id_memread;
    logic [4:0]  write1;
    logic [4:0]  write2;
    logic [4:0]  write3;
    logic        load_use_stall;
    logic [15:0] stall_count;

    modport master (
        output advance, flush, id_valid,
        output id_rs, id_rt, id_wsel,
        output id_regwen, id_memread,
        input  write1, write2, write3,
        input  load_use_stall, stall_count
    );

    modport slave (
        input  advance, flush, id_valid,
        input  id_rs, id_rt, id_wsel,
        input  id_regwen, id_memread,
        output write1, write2, write3,
        output load_use_stall, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination-tag scoreboard with load-use stall detection.
// Define HAZARD_STALL_COUNT_EN to build the saturating stall counter.
module hazard_scoreboard (
    input  logic CLK,
    input  logic nRST,
    hazard_scoreboard_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] tag;
        logic       is_load;
    } slot_t;

    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;
    slot_t ex_nxt;
    logic  writer;
    logic  rs_hit;
    logic  rt_hit;
    logic  stall;

    assign writer = bus.id_valid && bus.id_regwen
                 && (bus.id_wsel != 5'd0);

    assign rs_hit = (bus.id_rs != 5'd0)
                 && (bus.id_rs == ex_q.tag);
    assign rt_hit = (bus.id_rt != 5'd0)
                 && (bus.id_rt == ex_q.tag);

    assign stall = ex_q.valid && ex_q.is_load
                && bus.id_valid && (rs_hit || rt_hit)
                && !bus.flush;

    assign bus.load_use_stall = stall;
    assign bus.write1 = ex_q.valid  ? ex_q.tag  : 5'd0;
    assign bus.write2 = mem_q.valid ? mem_q.tag : 5'd0;
    assign bus.write3 = wb_q.valid  ? wb_q.tag  : 5'd0;

    // Next EX slot: real writer unless stalled or squashed.
    always_comb begin
        ex_nxt = '0;
        if (writer && !stall && !bus.flush) begin
            ex_nxt.valid   = 1'b1;
            ex_nxt.tag     = bus.id_wsel;
            ex_nxt.is_load = bus.id_memread;
        end
    end

    // Slot pipeline: shifts only when the pipeline advances.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (bus.advance) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_nxt;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] cnt_q;

    // Count advancing stall cycles, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= 16'd0;
        end else if (bus.advance && stall
                     && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

    typedef struct {
        string       name;
        logic [4:0]  w1;
        logic [4:0]  w2;
        logic [4:0]  w3;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

`ifdef HAZARD_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic CLK;
    logic nRST;
    int   tests;
    int   fails;
    exp_t q[$];

    hazard_scoreboard_if hif ();

    hazard_scoreboard dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (hif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (hif.write1 !== e.w1
                || hif.write2 !== e.w2
                || hif.write3 !== e.w3
                || hif.load_use_stall !== e.st
                || hif.stall_count !== e.cnt) begin
                fails++;
                $display("FAIL %s: got w=%0d/%0d/%0d st=%b cnt=%0d, want w=%0d/%0d/%0d st=%b cnt=%0d",
                         e.name, hif.write1, hif.write2,
                         hif.write3, hif.load_use_stall,
                         hif.stall_count, e.w1, e.w2, e.w3,
                         e.st, e.cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm,
                       input int w1, input int w2,
                       input int w3, input bit st,
                       input int cnt);
        exp_t e;
        e.name = nm;
        e.w1   = 5'(w1);
        e.w2   = 5'(w2);
        e.w3   = 5'(w3);
        e.st   = st;
        e.cnt  = CNT_EN ? 16'(cnt) : 16'd0;
        q.push_back(e);
    endtask

    task automatic drv(input bit adv, input bit fl,
                       input bit vld, input int rs,
                       input int rt, input int ws,
                       input bit rw, input bit mr);
        hif.advance    = adv;
        hif.flush      = fl;
        hif.id_valid   = vld;
        hif.id_rs      = 5'(rs);
        hif.id_rt      = 5'(rt);
        hif.id_wsel    = 5'(ws);
        hif.id_regwen  = rw;
        hif.id_memread = mr;
    endtask

    initial begin
        int guard;
        tests = 0;
        fails = 0;
        nRST  = 1'b0;
        drv(1, 1, 1, 0, 0, 7, 1, 0);
        cyc();
        cyc();
        nRST = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_idle", 0, 0, 0, 0, 0);
        cyc();
        chk("idle_hold", 0, 0, 0, 0, 0);

        // ALU write to r8 walks EX -> MEM -> WB -> retire.
        drv(1, 0, 1, 0, 0, 8, 1, 0);
        chk("alu_pre", 0, 0, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_ex", 8, 0, 0, 0, 0);
        cyc();
        chk("alu_mem", 0, 8, 0, 0, 0);
        cyc();
        chk("alu_wb", 0, 0, 8, 0, 0);
        cyc();
        chk("alu_retire", 0, 0, 0, 0, 0);

        // lw r9, then dependent rs=9 held with advance low.
        drv(1, 0, 1, 0, 0, 9, 1, 1);
        cyc();
        drv(0, 0, 1, 9, 0, 10, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("lu_hold", 9, 0, 0, 1, 0);
            cyc();
        end
        drv(1, 0, 1, 9, 0, 10, 1, 0);
        chk("lu_adv_pre", 9, 0, 0, 1, 0);
        cyc();
        chk("lu_bubble", 0, 9, 0, 0, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_resume", 10, 0, 9, 0, 1);
        cyc();

        // Flush together with a load-use on r9.
        drv(1, 0, 1, 0, 0, 9, 1, 1);
        cyc();
        drv(1, 1, 1, 9, 0, 5, 1, 0);
        chk("flush_stall", 9, 10, 0, 0, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_bubble", 0, 9, 10, 0, 1);
        cyc();

        // Fill all three slots, last one a load, then stall.
        drv(1, 0, 1, 0, 0, 3, 1, 0);
        cyc();
        drv(1, 0, 1, 0, 0, 4, 1, 0);
        cyc();
        drv(1, 0, 1, 0, 0, 6, 1, 1);
        cyc();
        drv(0, 0, 1, 0, 6, 6, 1, 0);
        chk("full_stall_rt", 6, 4, 3, 1, 1);
        cyc();

        // Reset mid-stall overrides advance.
        nRST = 1'b0;
        drv(1, 1, 1, 0, 6, 6, 1, 0);
        cyc();
        nRST = 1'b1;
        drv(1, 0, 1, 6, 0, 0, 1, 0);
        chk("rst_mid_stall", 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_dest", 0, 0, 0, 0, 0);
        cyc();

        // Identical tags in several slots; r0 source never stalls.
        drv(1, 0, 1, 0, 0, 12, 1, 1);
        cyc();
        drv(1, 0, 1, 0, 0, 12, 1, 0);
        cyc();
        drv(0, 0, 1, 0, 0, 1, 1, 0);
        chk("dup_tags_r0src", 12, 12, 0, 0, 0);
        cyc();

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            cyc();
            guard++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending, want 0",
                     q.size());
        end
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
